// File: rtl/nixie_pkg.sv
// Shared types and segment/COM encodings for the nixie display arbiter.
// Active-low segment order is {dp,g,f,e,d,c,b,a}.
package nixie_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_E    = 8'h86;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    localparam logic [1:0] COM_OFF  = 2'b11;
    localparam logic [1:0] COM_ONES = 2'b10;
    localparam logic [1:0] COM_TENS = 2'b01;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder (no dp).
// Non-BCD nibbles show 'E'; blank_i turns every segment off.
module seg7_decode
    import nixie_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [7:0] full;

    always_comb begin
        full  = seg_of(bcd_i);
        seg_o = blank_i ? SEG_OFF[6:0] : full[6:0];
    end

endmodule

// File: rtl/nixie_display_arbiter.sv
// Round-robin owner arbitration with minimum hold plus 2-digit display scan.
// Build option: NIXIE_BLANK_LEADING_ZERO_EN blanks a tens digit of 0.
module nixie_display_arbiter
    import nixie_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int SCAN_DIV = 25000,
    parameter int HOLD_CYC = 25000000
) (
    input  logic               Sys_CLK,
    input  logic               Sys_RST,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic               EN,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   ack,
    output logic [1:0]         COM,
    output logic [7:0]         SEG
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Highest priority is last+1, the previous owner itself comes last.
    function automatic logic [IW-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [IW-1:0]    last
    );
        logic [IW-1:0] pick;
        int            idx;
        pick = last;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % N_REQ;
            if (r[idx[IW-1:0]]) pick = idx[IW-1:0];
        end
        return pick;
    endfunction

    state_e         state_q, state_d;
    logic [IW-1:0]  last_q, last_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [7:0]     data_q, data_d;
    logic           dash_q, dash_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [SW-1:0]  scan_q;
    logic           digit_q;
    logic [1:0]     com_q;
    logic [7:0]     seg_q;

    logic [IW-1:0]    pick;
    logic [N_REQ-1:0] pick_oh;

    assign pick    = rr_pick(req, last_q);
    assign pick_oh = N_REQ'(1) << pick;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        data_d  = data_q;
        dash_d  = dash_q;
        grant_d = grant_q;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    data_d  = req_data[{pick, 3'b000} +: 8];
                    dash_d  = 1'b0;
                    ack_d   = pick_oh;
                    grant_d = pick_oh;
                    hold_d  = HW'(HOLD_CYC - 1);
                    last_d  = pick;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    if (|req) begin
                        data_d  = req_data[{pick, 3'b000} +: 8];
                        ack_d   = pick_oh;
                        grant_d = pick_oh;
                        hold_d  = HW'(HOLD_CYC - 1);
                        last_d  = pick;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                    if (req[last_q]) begin
                        data_d = req_data[{last_q, 3'b000} +: 8];
                        ack_d  = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [3:0] nib;
    logic       blank;
    logic [6:0] dec;
    logic [6:0] body;
    logic       dp_n;

    assign nib = digit_q ? data_q[7:4] : data_q[3:0];
`ifdef NIXIE_BLANK_LEADING_ZERO_EN
    assign blank = digit_q && (data_q[7:4] == 4'd0);
`else
    assign blank = 1'b0;
`endif

    seg7_decode u_dec (
        .bcd_i   (nib),
        .blank_i (blank),
        .seg_o   (dec)
    );

    assign body = dash_q ? SEG_DASH[6:0] : dec;
    assign dp_n = !(!digit_q && (|grant_q));

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            state_q <= IDLE;
            last_q  <= IW'(N_REQ - 1);
            hold_q  <= '0;
            data_q  <= '0;
            dash_q  <= 1'b1;
            grant_q <= '0;
            ack_q   <= '0;
            scan_q  <= '0;
            digit_q <= 1'b0;
            com_q   <= COM_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            dash_q  <= dash_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            if (scan_q == SW'(SCAN_DIV - 1)) begin
                scan_q  <= '0;
                digit_q <= ~digit_q;
            end else begin
                scan_q <= scan_q + 1'b1;
            end
            com_q <= EN ? (digit_q ? COM_TENS : COM_ONES) : COM_OFF;
            seg_q <= EN ? {dp_n, body} : SEG_OFF;
        end
    end

    assign grant = grant_q;
    assign ack   = ack_q;
    assign COM   = com_q;
    assign SEG   = seg_q;

endmodule

// File: tb/tb_nixie_display_arbiter.sv
// Self-checking bench for nixie_display_arbiter (N_REQ=3, SCAN_DIV=4, HOLD_CYC=16).
// Build with or without NIXIE_BLANK_LEADING_ZERO_EN.
module tb_nixie_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic        en;
    logic [2:0]  grant;
    logic [2:0]  ack;
    logic [1:0]  COM;
    logic [7:0]  SEG;

    int nvec;
    int nmis;
    int cyc;
    int t0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] ones;
        logic [7:0] tens;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    vec_t vt[5];
    sb_t  sbq[$];

`ifdef NIXIE_BLANK_LEADING_ZERO_EN
    localparam logic [7:0] TENS_ZERO = 8'hFF;
`else
    localparam logic [7:0] TENS_ZERO = 8'hC0;
`endif

    nixie_display_arbiter #(
        .N_REQ    (3),
        .SCAN_DIV (4),
        .HOLD_CYC (16)
    ) dut (
        .Sys_CLK  (clk),
        .Sys_RST  (rst),
        .req      (req),
        .req_data (req_data),
        .EN       (en),
        .grant    (grant),
        .ack      (ack),
        .COM      (COM),
        .SEG      (SEG)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_push(input string nm, input logic [7:0] e);
        sb_t s;
        s.name = nm;
        s.exp  = e;
        sbq.push_back(s);
    endtask

    task automatic seg_pop();
        sb_t s;
        if (sbq.size() == 0) begin
            nvec++;
            nmis++;
            $display("FAIL sb_empty: got none expected entry");
        end else begin
            s = sbq.pop_front();
            chk(s.name, SEG, s.exp);
        end
    endtask

    // Waits (bounded) for a digit slot, then checks the queued SEG value.
    task automatic wait_com(input logic [1:0] c);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (COM === c) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            nvec++;
            nmis++;
            $display("FAIL wait_com: got %b expected %b", COM, c);
            void'(sbq.pop_front());
        end else begin
            seg_pop();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drop();
        while (grant !== 3'b000 && cyc < t0 + 40) tick();
    endtask

    initial begin
        logic [2:0] seq[4];
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        en       = 1'b1;
        nvec     = 0;
        nmis     = 0;
        cyc      = 0;

        vt[0] = '{8'h42, 8'h24, 8'h99};
        vt[1] = '{8'h07, 8'h78, TENS_ZERO};
        vt[2] = '{8'hA3, 8'h30, 8'h86};
        vt[3] = '{8'h95, 8'h12, 8'h90};
        vt[4] = '{8'h0F, 8'h06, TENS_ZERO};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_com", COM, 2'b11);
        chk("rst_seg", SEG, 8'hFF);
        chk("rst_grant", grant, 3'b000);
        chk("rst_ack", ack, 3'b000);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("scan_com", COM, (i <= 4) ? 2'b10 : 2'b01);
            chk("dash_seg", SEG, 8'hBF);
            chk("idle_grant", grant, 3'b000);
        end

        // single owner: hold length and display after release
        do_reset();
        req_data[15:8] = 8'h42;
        req = 3'b010;
        tick();
        chk("h42_ack", ack, 3'b010);
        chk("h42_grant", grant, 3'b010);
        t0  = cyc;
        req = '0;
        tick();
        chk("h42_ack_width", ack, 3'b000);
        exp_push("h42_ones", 8'h24);
        wait_com(2'b10);
        exp_push("h42_tens", 8'h99);
        wait_com(2'b01);
        wait_drop();
        chk("h42_hold_len", cyc - t0, 16);
        tick();
        exp_push("h42_ones_nodp", 8'hA4);
        wait_com(2'b10);
        exp_push("h42_tens_after", 8'h99);
        wait_com(2'b01);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            req_data[15:8] = vt[v].data;
            req = 3'b010;
            tick();
            chk("vec_ack", ack, 3'b010);
            req = '0;
            tick();
            exp_push("vec_ones", vt[v].ones);
            wait_com(2'b10);
            exp_push("vec_tens", vt[v].tens);
            wait_com(2'b01);
        end

        // req0 and req2 together
        do_reset();
        req_data = 24'h11_22_33;
        req = 3'b101;
        tick();
        chk("rr02_grant0", grant, 3'b001);
        chk("rr02_ack0", ack, 3'b001);
        req[0] = 1'b0;
        repeat (15) tick();
        chk("rr02_still0", grant, 3'b001);
        tick();
        chk("rr02_grant2", grant, 3'b100);
        chk("rr02_ack2", ack, 3'b100);
        req = '0;

        // all requesters held high
        seq[0] = 3'b001;
        seq[1] = 3'b010;
        seq[2] = 3'b100;
        seq[3] = 3'b001;
        do_reset();
        req = 3'b111;
        tick();
        chk("all_grant", grant, seq[0]);
        chk("all_ack", ack, seq[0]);
        for (int k = 1; k < 4; k++) begin
            repeat (15) tick();
            chk("all_still", grant, seq[k-1]);
            tick();
            chk("all_grant", grant, seq[k]);
            chk("all_ack", ack, seq[k]);
        end
        req = '0;

        // EN dropped mid-hold
        do_reset();
        req_data[15:8] = 8'hA3;
        req = 3'b010;
        tick();
        chk("en_ack", ack, 3'b010);
        t0  = cyc;
        req = '0;
        tick();
        exp_push("en_tens_E", 8'h86);
        wait_com(2'b01);
        en = 1'b0;
        tick();
        chk("en_off_com", COM, 2'b11);
        chk("en_off_seg", SEG, 8'hFF);
        chk("en_off_grant", grant, 3'b010);
        wait_drop();
        chk("en_hold_len", cyc - t0, 16);
        tick();
        chk("en_off_com2", COM, 2'b11);
        chk("en_off_seg2", SEG, 8'hFF);
        en = 1'b1;

        // reset mid-hold restores dash
        req = 3'b010;
        tick();
        req = '0;
        do_reset();
        tick();
        chk("rst_mid_grant", grant, 3'b000);
        chk("rst_mid_dash", SEG, 8'hBF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
